// File: rtl/sync_fifo_fwft_if.sv
// sync_fifo_fwft_if: valid/ready stream bundle between a producer, the FIFO and a consumer
//   in_data/in_valid/in_ready    : write side (producer -> FIFO)
//   out_data/out_valid/out_ready : read side (FIFO -> consumer)
//   master modport: the producer/consumer environment; slave modport: the FIFO
interface sync_fifo_fwft_if #(
    parameter int DW = 8
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO on an inferred SDP RAM with registered read
//   clk, rst     : clock and synchronous active-high reset
//   bus (slave)  : in_data/in_valid/in_ready write side, out_data/out_valid/out_ready read side
//   count        : words held, 0..DEPTH, including the word sitting in the output register
//   SYNC_FIFO_ALMOST_EN adds AF_LEVEL/AE_LEVEL and registered almost_full/almost_empty outputs
module sync_fifo_fwft #(
    parameter int DW    = 8,
    parameter int DEPTH = 256
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    sync_fifo_fwft_if.slave        bus,
    output logic [$clog2(DEPTH):0] count
`ifdef SYNC_FIFO_ALMOST_EN
    ,
    output logic                   almost_full,
    output logic                   almost_empty
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ram_cnt, ram_cnt_nxt, count_nxt;
    logic [DW-1:0] out_data;
    logic          out_valid, out_valid_nxt, wr_acc, rd_en;
    assign bus.in_ready  = count != FULL;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign wr_acc = bus.in_valid && bus.in_ready;
    // ram_cnt only counts completed writes, so a fetch never targets the address being written
    assign rd_en = (ram_cnt != '0) && (!out_valid || bus.out_ready);
    always_comb begin
        out_valid_nxt = rd_en ? 1'b1 : bus.out_ready ? 1'b0 : out_valid;
        ram_cnt_nxt   = ram_cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_en};
        count_nxt     = ram_cnt_nxt + {{AW{1'b0}}, out_valid_nxt};
    end
    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= bus.in_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(wr_acc);
            rd_ptr    <= rd_ptr + AW'(rd_en);
            ram_cnt   <= ram_cnt_nxt;
            count     <= count_nxt;
            out_valid <= out_valid_nxt;
            if (rd_en) out_data <= mem[rd_ptr];
        end
    end
`ifdef SYNC_FIFO_ALMOST_EN
    localparam logic [CW-1:0] AF = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE = CW'(AE_LEVEL);
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= count_nxt >= AF;
            almost_empty <= count_nxt <= AE;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: randomized and directed checks of sync_fifo_fwft against a queue reference model
module tb_sync_fifo_fwft;
    localparam int DA = 4;
    localparam int DB = 256;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    sync_fifo_fwft_if #(.DW(8))  a_if ();
    sync_fifo_fwft_if #(.DW(16)) b_if ();
    logic [2:0] a_cnt;
    logic [8:0] b_cnt;
`ifdef SYNC_FIFO_ALMOST_EN
    logic a_af, a_ae, b_af, b_ae, c_af, c_ae;
    logic [3:0] c_cnt;
    sync_fifo_fwft_if #(.DW(8)) c_if ();
    sync_fifo_fwft #(.DW(8), .DEPTH(DA)) dut_a (.clk(clk), .rst(rst), .bus(a_if), .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae));
    sync_fifo_fwft #(.DW(16), .DEPTH(DB)) dut_b (.clk(clk), .rst(rst), .bus(b_if), .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae));
    sync_fifo_fwft #(.DW(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut_c (.clk(clk), .rst(rst), .bus(c_if), .count(c_cnt), .almost_full(c_af), .almost_empty(c_ae));
`else
    sync_fifo_fwft #(.DW(8), .DEPTH(DA)) dut_a (.clk(clk), .rst(rst), .bus(a_if), .count(a_cnt));
    sync_fifo_fwft #(.DW(16), .DEPTH(DB)) dut_b (.clk(clk), .rst(rst), .bus(b_if), .count(b_cnt));
`endif
    int n_chk = 0;
    int n_fail = 0;
    // reference: contents in order, plus the edge number at which each word was written;
    // a word becomes visible at the output only after an edge later than its write edge
    logic [7:0] q_d[$];
    int q_t[$];
    int edge_n = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic bit a_vis();
        return q_d.size() > 0 && q_t[0] < edge_n;
    endfunction
    task automatic cmp_a();
        bit v;
        v = a_vis();
        chk("a_count", 32'(a_cnt), 32'(q_d.size()));
        chk("a_in_ready", 32'(a_if.in_ready), 32'(q_d.size() < DA));
        chk("a_out_valid", 32'(a_if.out_valid), 32'(v));
        if (v) chk("a_out_data", 32'(a_if.out_data), 32'(q_d[0]));
    endtask
    task automatic tick();
        bit rd, wr;
        logic [7:0] d;
        rd = a_vis() && a_if.out_ready;
        wr = a_if.in_valid && q_d.size() < DA;
        d = a_if.in_data;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q_d.delete();
            q_t.delete();
        end else begin
            if (rd) begin
                void'(q_d.pop_front());
                void'(q_t.pop_front());
            end
            if (wr) begin
                q_d.push_back(d);
                q_t.push_back(edge_n);
            end
        end
        @(negedge clk);
        cmp_a();
    endtask
    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        a_if.in_valid  = v;
        a_if.in_data   = d;
        a_if.out_ready = r;
    endtask
    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask
    initial begin
        int b_sent, b_got;
        bit b_started;
        drive(0, 0, 0);
        b_if.in_valid = 0; b_if.in_data = 0; b_if.out_ready = 0;
`ifdef SYNC_FIFO_ALMOST_EN
        c_if.in_valid = 0; c_if.in_data = 0; c_if.out_ready = 0;
`endif
        @(negedge clk);
        do_reset();
        chk("rst_out_data", 32'(a_if.out_data), 0);
        chk("rst_b_count", 32'(b_cnt), 0);
        // single word into empty FIFO, then hold
        drive(1, 8'h11, 0);
        tick();
        drive(0, 0, 0);
        repeat (6) tick();
        chk("single_data", 32'(a_if.out_data), 32'h11);
        // fill to full, offer while full, drain
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 8'(i), 0);
            tick();
        end
        chk("full_in_ready", 32'(a_if.in_ready), 0);
        drive(1, 8'h05, 0);
        repeat (2) tick();
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(a_if.out_data), 32'(i));
            drive(0, 0, 1);
            tick();
        end
        repeat (2) tick();
        chk("drain_empty_count", 32'(a_cnt), 0);
        // random traffic
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
        // reset mid-transfer
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h30 + i), 0);
            tick();
        end
        drive(1, 8'h55, 1);
        do_reset();
        chk("midrst_out_data", 32'(a_if.out_data), 0);
        chk("midrst_in_ready", 32'(a_if.in_ready), 1);
        drive(1, 8'hAA, 0);
        tick();
        drive(0, 0, 0);
        tick();
        chk("midrst_first_word", 32'(a_if.out_data), 32'hAA);
        chk("midrst_first_valid", 32'(a_if.out_valid), 1);
        // streaming throughput on the deep FIFO
        b_sent = 0; b_got = 0; b_started = 0;
        for (int c = 0; c < 1200 && b_got < 1024; c++) begin
            b_if.in_valid  = b_sent < 1024;
            b_if.in_data   = 16'(b_sent);
            b_if.out_ready = 1;
            if (b_if.in_valid && b_if.in_ready) b_sent++;
            tick();
            chk("b_count_le2", 32'(b_cnt <= 2), 1);
            if (b_started) chk("b_steady_valid", 32'(b_if.out_valid), 1);
            if (b_if.out_valid) begin
                chk("b_order", 32'(b_if.out_data), 32'(b_got));
                b_got++;
                b_started = 1;
            end
        end
        chk("b_all_words", 32'(b_got), 1024);
        b_if.in_valid = 0; b_if.out_ready = 0;
`ifdef SYNC_FIFO_ALMOST_EN
        do_reset();
        chk("c_rst_af", 32'(c_af), 0);
        chk("c_rst_ae", 32'(c_ae), 1);
        for (int i = 0; i < 8; i++) begin
            c_if.in_valid = 1; c_if.in_data = 8'(i); c_if.out_ready = 0;
            tick();
            chk("c_fill_count", 32'(c_cnt), 32'(i + 1));
            chk("c_fill_af", 32'(c_af), 32'(i + 1 >= 6));
            chk("c_fill_ae", 32'(c_ae), 32'(i + 1 <= 2));
        end
        c_if.in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            chk("c_drain_data", 32'(c_if.out_data), 32'(i));
            c_if.out_ready = 1;
            tick();
            chk("c_drain_count", 32'(c_cnt), 32'(7 - i));
            chk("c_drain_af", 32'(c_af), 32'(7 - i >= 6));
            chk("c_drain_ae", 32'(c_ae), 32'(7 - i <= 2));
        end
        c_if.out_ready = 0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, first-word-fall-through FIFO with a valid/ready handshake on both sides.
- Storage is an inferred simple-dual-port RAM with a registered read port: one write port, one read port with one cycle of read latency.
- The RAM's registered read data is the FIFO output register.
- Sits between a streaming producer (e.g. a sample generator) and a consumer that may stall, and absorbs rate mismatch.

Parameters:
- DW, 8, data width in bits.
- DEPTH, 256, total capacity in words. Must be a power of 2 and ≥ 4. Also the RAM word count.
- AW, $clog2(DEPTH), pointer width (localparam).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  DW  write data.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- out_data  out  DW  head word. Valid only while out_valid=1.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer takes head word.
- count  out  AW+1  words held, 0..DEPTH. Includes the word in the output register.

Behaviour:
- Write accept: in_valid && in_ready at an edge. Writes ram[wr_ptr] and increments wr_ptr (wraps modulo DEPTH).
- Read accept: out_valid && out_ready at an edge. The head word is consumed.
- Internal ram_cnt = words in the RAM not yet fetched to the output register.
- rd_en = (ram_cnt != 0) && (!out_valid || out_ready).
  - On rd_en: out_data <= ram[rd_ptr], rd_ptr++ (wraps).
- out_valid next state:
  - 1 if rd_en;
  - else 0 if out_ready;
  - else hold.
- out_data changes only on rd_en. It stays stable while out_valid && !out_ready.
- ram_cnt next = ram_cnt + write_accept − rd_en.
- count = ram_cnt + out_valid. Registered, updated every edge.
- Latency: a word accepted at edge k into an empty FIFO gives out_valid=1 and out_data=word after edge k+1. No combinational in→out path.
- Throughput: one word per cycle sustained in both directions simultaneously.
- Full (count == DEPTH): in_ready=0. A read accept in the same cycle does not admit a write in that cycle; in_ready rises after the edge.
- Empty (count == 0): out_valid=0, no bypass. A simultaneous write does not appear at the output until after the next edge.
- Simultaneous write + read accept at count in 1..DEPTH−1: count unchanged, ordering preserved.
- Read/write address collision: rd_en is never asserted on the address being written in the same cycle, because ram_cnt counts only completed writes. The RAM's read-during-write mode is therefore irrelevant.
- Pointer wrap: DEPTH is a power of 2, so pointers wrap naturally. Ordering must survive many wraps.
- Reset (any time, including mid-transfer), after the edge:
  - wr_ptr = rd_ptr = ram_cnt = 0;
  - out_valid = 0, out_data = 0, count = 0, in_ready = 1;
  - RAM contents not cleared; stale data is never presented.
- Writes while in_ready=0 and reads while out_valid=0 are ignored; they never corrupt state.

Optional Feature:
- Macro: SYNC_FIFO_ALMOST_EN.
- When defined:
  - Adds parameters AF_LEVEL (default DEPTH−2) and AE_LEVEL (default 2).
  - Adds output almost_full, 1 bit, registered: 1 iff next count ≥ AF_LEVEL.
  - Adds output almost_empty, 1 bit, registered: 1 iff next count ≤ AE_LEVEL.
  - Both flags update on the same edge as count. Reset values: almost_full=0, almost_empty=1.
- When undefined: the two ports and parameters do not exist; all other behaviour is identical.

Test Plan (DW=8, DEPTH=4 unless noted):
- Reset, then in_valid=1 with data 0x11 for one cycle at edge k, out_ready=0 -> after k+1: out_valid=1, out_data=0x11, count=1; held stable for 5 cycles.
- Write 0x01..0x04 back-to-back with out_ready=0 -> count=4 and in_ready=0. 0x05 offered while full is not accepted. Drain with out_ready=1 -> outputs 0x01,0x02,0x03,0x04 on consecutive cycles, then out_valid=0 and count=0.
- Continuous in_valid=1, out_ready=1, data 0..1023 incrementing, DEPTH=256 -> all 1024 words out in order, count ≤ 2 throughout, exactly one word per cycle in steady state.
- Random in_valid and out_ready (50%) over 10000 cycles against a reference queue -> zero data mismatches; count always equals queue size; no accept while full or empty.
- Fill to 3 words, assert rst for one cycle while in_valid=out_ready=1 -> after the edge: count=0, out_valid=0, out_data=0, in_ready=1. The next written word 0xAA is the first word out.
- With SYNC_FIFO_ALMOST_EN, DEPTH=8, AF=6, AE=2: fill 0..7 -> almost_empty drops as count reaches 3, almost_full rises as count reaches 6; both mirror on drain.
